// File: rtl/time_display_scan.sv
// Six-digit multiplexed seven-segment driver for the hh:mm:ss counters.
// Optional build macro DISP_LZB_EN blanks the hours tens digit when it is zero.
module time_display_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic [6:0] seg,
    output logic [5:0] dig_sel,
    output logic       frame_tick,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SUB   = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DIV_W-1:0] pre;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic             wrap;
    logic             capture;
    logic             commit;

    logic [5:0] sh_h;
    logic [5:0] sh_m;
    logic [5:0] sh_s;

    logic [1:0] fld;
    logic [5:0] field_val;
    logic [5:0] working;
    logic [3:0] tens;

    // Digit slot 5 = hours tens ... slot 0 = seconds ones.
    logic [5:0][3:0] pend;
    logic [5:0][3:0] disp;
    logic [5:0][3:0] disp_nxt;
    logic            blank;
    logic            blank_nxt;
    logic [3:0]      cur_digit;
    logic [6:0]      seg_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // Slot timing: the prescaler wrap is the only event that moves idx.
    always_comb begin
        wrap    = (pre == DIV_W'(SCAN_DIV - 1));
        idx_nxt = idx;
        if (wrap) begin
            idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
        capture = wrap && (idx == 3'd4);
        commit  = wrap && (idx == 3'd5) && (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= 3'd0;
        end else begin
            pre <= wrap ? '0 : pre + DIV_W'(1);
            idx <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_h <= '0;
            sh_m <= '0;
            sh_s <= '0;
        end else if (capture) begin
            sh_h <= hours;
            sh_m <= minutes;
            sh_s <= seconds;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (capture) state_nxt = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = SUB;
            end
            SUB: begin
                busy = 1'b1;
                if (working < 6'd10) state_nxt = STORE;
            end
            STORE: begin
                busy      = 1'b1;
                state_nxt = (fld == 2'd2) ? DONE : LOAD;
            end
            DONE: begin
                if (commit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (fld)
            2'd0:    field_val = sh_h;
            2'd1:    field_val = sh_m;
            default: field_val = sh_s;
        endcase
    end

    // Repeated subtraction: at most six steps per field, since inputs are 6 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fld     <= 2'd0;
            working <= '0;
            tens    <= '0;
            pend    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) fld <= 2'd0;
                end
                LOAD: begin
                    working <= field_val;
                    tens    <= 4'd0;
                end
                SUB: begin
                    if (working >= 6'd10) begin
                        working <= working - 6'd10;
                        tens    <= tens + 4'd1;
                    end
                end
                STORE: begin
                    case (fld)
                        2'd0: begin
                            pend[5] <= tens;
                            pend[4] <= working[3:0];
                        end
                        2'd1: begin
                            pend[3] <= tens;
                            pend[2] <= working[3:0];
                        end
                        default: begin
                            pend[1] <= tens;
                            pend[0] <= working[3:0];
                        end
                    endcase
                    fld <= fld + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are computed from next-cycle values so seg and dig_sel switch together.
    always_comb begin
        disp_nxt  = commit ? pend : disp;
        blank_nxt = commit ? 1'b0 : blank;
        case (idx_nxt)
            3'd0:    cur_digit = disp_nxt[0];
            3'd1:    cur_digit = disp_nxt[1];
            3'd2:    cur_digit = disp_nxt[2];
            3'd3:    cur_digit = disp_nxt[3];
            3'd4:    cur_digit = disp_nxt[4];
            default: cur_digit = disp_nxt[5];
        endcase
        seg_nxt = glyph(cur_digit);
`ifdef DISP_LZB_EN
        if ((idx_nxt == 3'd5) && (cur_digit == 4'd0)) seg_nxt = 7'h00;
`endif
        if (blank_nxt) seg_nxt = 7'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp       <= '0;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
            seg        <= 7'h00;
            dig_sel    <= 6'b000000;
        end else begin
            disp       <= disp_nxt;
            blank      <= blank_nxt;
            frame_tick <= commit;
            seg        <= seg_nxt;
            dig_sel    <= blank_nxt ? 6'b000000 : (6'b000001 << idx_nxt);
        end
    end

endmodule

// File: doc/time_display_scan.md
Name: time_display_scan

Overview:
- Consumer side of the clock counters. Takes the binary hour, minute and second counts from the counter chain and converts each one to two BCD digits.
- Drives a 6-digit multiplexed seven-segment display, one digit per scan slot.
- Sits between the counter24/counter60 chain and the board display pins.
- Converts sequentially and commits all six digits at once per frame, so no torn time is ever shown.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot. Legal range 32..65535.
- DIV_W, 16: prescaler width. Must satisfy 2^DIV_W > SCAN_DIV.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hours  in  6  binary hour count, 0..23 nominal.
- minutes  in  6  binary minute count, 0..59 nominal.
- seconds  in  6  binary second count, 0..59 nominal.
- seg  out  7  segment drive, active-high, bit order gfedcba.
- dig_sel  out  6  one-hot digit enable, active-high. Bit 5 = hours tens, bit 0 = seconds ones.
- frame_tick  out  1  one-cycle pulse on the edge that commits new display digits.
- busy  out  1  high while conversion is in progress.

Behaviour:
- Reset (async, rst_n=0):
  - prescaler=0, digit index idx=0, conversion FSM=IDLE.
  - All six display BCD registers = 0.
  - Outputs: seg=0, dig_sel=0, frame_tick=0, busy=0, blank=1.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx advances 0→1→…→5→0.
- Capture:
  - On the edge where idx goes 4→5, snapshot hours, minutes and seconds into shadow registers.
  - The conversion FSM leaves IDLE on the same edge.
  - Input changes after that edge do not affect the frame.
- Conversion FSM (fields processed in order H, M, S):
  - IDLE → LOAD: working reg = shadow field, tens=0.
  - LOAD → SUB. In SUB, while working ≥ 10: working -= 10, tens += 1, one subtraction per cycle.
  - SUB → STORE when working < 10. STORE writes pending tens/ones for the field, then goes to LOAD of the next field, or to DONE after S.
  - DONE holds until commit, then returns to IDLE.
  - Worst case is under 30 cycles, so conversion always completes inside the digit-5 slot.
  - busy=1 in every state except IDLE and DONE.
- Arithmetic:
  - Inputs 60..63 convert naturally (tens=6, ones=0..3). No clamping, no error flag.
  - A tens value of 6 has a valid glyph.
- Commit:
  - On the edge where idx goes 5→0 with FSM in DONE: all six pending digits copy to the display registers, frame_tick=1 for one cycle, blank clears to 0.
  - If FSM is not in DONE at that edge (illegal SCAN_DIV only): no commit, previous digits are kept.
- Output registers:
  - dig_sel = 1<<idx, registered; 0 while blank=1.
  - seg = glyph(display digit[idx]), registered, aligned with dig_sel.
  - Glyphs 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - After reset the display stays dark until the first commit, at 6*SCAN_DIV cycles.
- Reset mid-conversion or mid-frame: immediate return to reset values. Pending digits are discarded.

Optional Feature:
- Macro: DISP_LZB_EN (leading-zero blanking of the hours tens digit).
- Defined: when the committed hours tens digit = 0, seg=0 during the idx=5 slot. dig_sel[5] is still asserted, so slot timing is unchanged.
- Undefined: the hours tens digit always shows its glyph, including "0" (3F).

Test Plan:
- Reset/startup: SCAN_DIV=32, hold inputs 13:45:07, release rst_n.
  → dig_sel=0 and seg=0 for the first 192 cycles.
  → Then frame_tick pulses once.
  → Slots 5..0 show 06,4F,66,6D,3F,07.
- Frame atomicity: change inputs 13:45:07→14:00:00 during the idx=5 slot, after the capture edge.
  → The next frame still shows 13:45:07.
  → The frame after that shows 14:00:00.
- Conversion bounds: hours=23, minutes=59, seconds=63 with SCAN_DIV=32.
  → busy deasserts before the 5→0 edge.
  → Digits shown: 2,3,5,9,6,3 (seconds tens = 7D).
- Scan timing: count cycles between dig_sel changes.
  → Exactly 32 cycles each.
  → One-hot sequence 000001→000010→…→100000→000001.
  → frame_tick pulses every 192 cycles.
- Async reset mid-SUB: assert rst_n=0 while busy=1.
  → seg, dig_sel, busy and frame_tick go to 0 without waiting for a clock.
  → After release, the startup behaviour repeats.
- DISP_LZB_EN: hours=5.
  → With the macro defined, slot 5 has seg=00.
  → Without it, slot 5 has seg=3F.
  → Slot 4 shows 6D in both builds.
